arbitrated_drain: RTL and testbench

Receive-side endpoint for the arbitrated FIFO bank. It drives the bank's per-FIFO `reqs` and accepts the granted word on the shared data bus each cycle a one-hot `gnt` arrives. Each word is tagged with the encoded grant index and buffered, then delivered downstream on a valid/ready interface. Per-source occupancy limits keep one FIFO from monopolising the buffer, and grants that violate the protocol are flagged.

---
 rtl/arbitrated_drain.sv | 110 +++++++++++
 tb/tb_arbitrated_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitrated_drain.sv
// Receive-side endpoint of the arbitrated FIFO bank: tags granted words,
// buffers them FWFT and caps per-source occupancy.
module arbitrated_drain #(
  parameter int NUM_FIFOS   = 4,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int MAX_PER_SRC = 2,
  parameter int TAGWIDTH    = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] src_en,
  input  logic [NUM_FIFOS-1:0] gnt,
  input  logic [WIDTH-1:0]     data_in,
  output logic [NUM_FIFOS-1:0] reqs,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAGWIDTH-1:0]  out_tag,
  output logic                 protocol_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_PER_SRC + 1);
  localparam int EW = TAGWIDTH + WIDTH;

  logic [EW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_src_cnt [NUM_FIFOS];
  logic                r_err;

  logic                w_space;
  logic                w_onehot;
  logic                w_push;
  logic                w_bad;
  logic                w_pop;
  logic [TAGWIDTH-1:0] w_tag;
  logic [EW-1:0]       w_head;
  logic [NUM_FIFOS-1:0] w_inc;
  logic [NUM_FIFOS-1:0] w_dec;

  // reqs must stay independent of gnt/out_rdy to avoid a loop via the arbiter
  assign w_space = (r_count < CW'(DEPTH));

  always_comb begin
    reqs = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      reqs[i] = !rst && src_en[i] && w_space &&
                (r_src_cnt[i] < SW'(MAX_PER_SRC));
    end
  end

  always_comb begin
    w_tag = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i]) w_tag = TAGWIDTH'(i);
    end
  end

  assign w_onehot = (gnt != '0) && ((gnt & (gnt - 1'b1)) == '0);
  assign w_push   = w_onehot && ((gnt & ~reqs) == '0);
  assign w_bad    = (gnt != '0) && !w_push;

  assign w_head   = r_mem[r_rd];
  assign out_vld  = (r_count != '0);
  assign out_data = w_head[WIDTH-1:0];
  assign out_tag  = w_head[EW-1:WIDTH];
  assign w_pop    = out_vld && out_rdy;
  assign protocol_err = r_err;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      w_inc[i] = w_push && gnt[i];
      w_dec[i] = w_pop && (out_tag == TAGWIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_tag, data_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) r_src_cnt[i] <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_bad) r_err <= 1'b1;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        unique case ({w_inc[i], w_dec[i]})
          2'b10:   r_src_cnt[i] <= r_src_cnt[i] + SW'(1);
          2'b01:   r_src_cnt[i] <= r_src_cnt[i] - SW'(1);
          default: r_src_cnt[i] <= r_src_cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_drain.sv
// Self-checking bench for arbitrated_drain against a queue-based model.
module tb_arbitrated_drain;

  localparam int N = 4;
  localparam int DEPTH = 4;
  localparam int MAXS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_en;
  logic [3:0] gnt;
  logic [7:0] data_in;
  logic [3:0] reqs;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic       protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] q[$];
  logic       m_err;

  arbitrated_drain dut (
    .clk(clk), .rst(rst), .src_en(src_en), .gnt(gnt),
    .data_in(data_in), .reqs(reqs), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_tag(out_tag),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_reqs();
    logic [3:0] r;
    int c;
    r = '0;
    for (int i = 0; i < N; i++) begin
      c = 0;
      foreach (q[k]) if (q[k][9:8] == 2'(i)) c++;
      r[i] = !rst && src_en[i] && (q.size() < DEPTH) && (c < MAXS);
    end
    return r;
  endfunction

  function automatic logic [3:0] pick_legal();
    logic [3:0] r;
    int idx[$];
    r = m_reqs();
    for (int i = 0; i < N; i++) if (r[i]) idx.push_back(i);
    if (idx.size() == 0) return 4'b0000;
    return 4'b0001 << idx[$urandom_range(idx.size() - 1)];
  endfunction

  task automatic drive(input logic [3:0] g, input logic [7:0] d,
                       input logic rdy);
    logic [3:0] r;
    logic       legal;
    logic       pop;
    logic [1:0] t;
    gnt = g;
    data_in = d;
    out_rdy = rdy;
    @(posedge clk);
    r = m_reqs();
    legal = ($countones(g) == 1) && ((g & ~r) == 4'b0);
    pop = (q.size() > 0) && rdy;
    t = 2'd0;
    for (int i = 0; i < N; i++) if (g[i]) t = 2'(i);
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (legal) q.push_back({t, d});
      if (g != 4'b0 && !legal) m_err = 1'b1;
    end
    #1;
    gnt = 4'b0;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_en = 4'b1111;
    drive(4'b0, 8'h00, 1'b0);
    n_tests++;
    if (reqs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_reqs_in_rst got=%b want=0000", reqs);
    end
    rst = 1'b0;
    drive(4'b0, 8'h00, 1'b0);
    n_tests++;
    if (reqs !== 4'b1111 || out_vld !== 1'b0 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got reqs=%b vld=%b err=%b want 1111/0/0",
               reqs, out_vld, protocol_err);
    end
  endtask

  task automatic test_fwft();
    drive(4'b0001, 8'hA0, 1'b0);
    n_tests++;
    if (out_vld !== 1'b1 || out_data !== 8'hA0 || out_tag !== 2'd0) begin
      n_fail++;
      $display("FAIL fwft_first got vld=%b %h/%0d want 1 a0/0",
               out_vld, out_data, out_tag);
    end
    drive(4'b0100, 8'hA2, 1'b0);
    n_tests++;
    if (out_data !== 8'hA0 || out_tag !== 2'd0) begin
      n_fail++;
      $display("FAIL fwft_hold got %h/%0d want a0/0", out_data, out_tag);
    end
    drive(4'b0, 8'h00, 1'b1);
    n_tests++;
    if (out_vld !== 1'b1 || out_data !== 8'hA2 || out_tag !== 2'd2) begin
      n_fail++;
      $display("FAIL fwft_second got vld=%b %h/%0d want 1 a2/2",
               out_vld, out_data, out_tag);
    end
    drive(4'b0, 8'h00, 1'b1);
    n_tests++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_empty got vld=%b want 0", out_vld);
    end
  endtask

  task automatic test_src_cap();
    drive(4'b0010, 8'hB1, 1'b0);
    drive(4'b0010, 8'hB2, 1'b0);
    n_tests++;
    if (reqs !== 4'b1101) begin
      n_fail++;
      $display("FAIL cap_drop got=%b want=1101", reqs);
    end
    drive(4'b0, 8'h00, 1'b1);
    n_tests++;
    if (reqs !== 4'b1111 || out_data !== 8'hB2) begin
      n_fail++;
      $display("FAIL cap_rise got reqs=%b head=%h want 1111/b2",
               reqs, out_data);
    end
    drive(4'b0, 8'h00, 1'b1);
  endtask

  task automatic test_full_wrap();
    logic [3:0] g;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) drive(4'b0001 << i, 8'hC0 + 8'(i), 1'b0);
    n_tests++;
    if (reqs !== 4'b0000 || out_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL full_reqs got reqs=%b head=%h want 0000/c0",
               reqs, out_data);
    end
    out_rdy = 1'b1;
    #1;
    n_tests++;
    if (reqs !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_pop_same_cycle got=%b want=0000", reqs);
    end
    drive(4'b0, 8'h00, 1'b1);
    n_tests++;
    if (reqs !== m_reqs() || reqs === 4'b0000) begin
      n_fail++;
      $display("FAIL full_reenable got=%b want=%b", reqs, m_reqs());
    end
    drive(4'b0001, 8'hC4, 1'b1);
    d = 8'hD0;
    for (int i = 0; i < 12; i++) begin
      g = pick_legal();
      drive(g, d, 1'b1);
      d++;
      n_tests++;
      if (out_vld !== (q.size() != 0) || reqs !== m_reqs() ||
          (q.size() != 0 && {out_tag, out_data} !== q[0])) begin
        n_fail++;
        $display("FAIL wrap_%0d got vld=%b reqs=%b head=%h want %b/%b/%h",
                 i, out_vld, reqs, {out_tag, out_data},
                 q.size() != 0, m_reqs(), (q.size() != 0) ? q[0] : 10'h0);
      end
    end
    while (q.size() != 0) drive(4'b0, 8'h00, 1'b1);
  endtask

  task automatic test_protocol_err();
    drive(4'b0001, 8'hE0, 1'b0);
    drive(4'b0011, 8'hE1, 1'b0);
    n_tests++;
    if (protocol_err !== 1'b1 || out_data !== 8'hE0) begin
      n_fail++;
      $display("FAIL err_multi got err=%b head=%h want 1/e0",
               protocol_err, out_data);
    end
    drive(4'b0, 8'h00, 1'b1);
    n_tests++;
    if (protocol_err !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_write got err=%b vld=%b want 1/0",
               protocol_err, out_vld);
    end
    rst = 1'b1;
    drive(4'b0, 8'h00, 1'b0);
    rst = 1'b0;
    src_en = 4'b1011;
    drive(4'b0, 8'h00, 1'b0);
    n_tests++;
    if (protocol_err !== 1'b0 || reqs !== 4'b1011) begin
      n_fail++;
      $display("FAIL err_cleared got err=%b reqs=%b want 0/1011",
               protocol_err, reqs);
    end
    drive(4'b0100, 8'hE2, 1'b0);
    drive(4'b0, 8'h00, 1'b0);
    drive(4'b0, 8'h00, 1'b0);
    n_tests++;
    if (protocol_err !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL err_masked got err=%b vld=%b want 1/0",
               protocol_err, out_vld);
    end
    src_en = 4'b1111;
  endtask

  task automatic test_mid_reset();
    drive(4'b0001, 8'hF0, 1'b0);
    drive(4'b0010, 8'hF1, 1'b0);
    drive(4'b1000, 8'hF3, 1'b0);
    rst = 1'b1;
    drive(4'b0, 8'h00, 1'b0);
    rst = 1'b0;
    src_en = 4'b0110;
    #1;
    n_tests++;
    if (out_vld !== 1'b0 || reqs !== 4'b0110 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got vld=%b reqs=%b err=%b want 0/0110/0",
               out_vld, reqs, protocol_err);
    end
    src_en = 4'b1111;
  endtask

  task automatic test_random();
    logic [3:0] g;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) src_en = 4'($urandom);
      g = ($urandom_range(3) == 0) ? 4'b0 : pick_legal();
      drive(g, 8'($urandom), 1'($urandom));
      n_tests++;
      if (out_vld !== (q.size() != 0) || reqs !== m_reqs() ||
          protocol_err !== m_err ||
          (q.size() != 0 && {out_tag, out_data} !== q[0])) begin
        n_fail++;
        $display("FAIL rand_%0d got vld=%b reqs=%b err=%b head=%h want %b/%b/%b/%h",
                 i, out_vld, reqs, protocol_err, {out_tag, out_data},
                 q.size() != 0, m_reqs(), m_err,
                 (q.size() != 0) ? q[0] : 10'h0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    src_en = 4'b0;
    gnt = 4'b0;
    data_in = 8'h00;
    out_rdy = 1'b0;
    m_err = 1'b0;
    test_reset();
    test_fwft();
    test_src_cap();
    test_full_wrap();
    test_protocol_err();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
